fifo_1w1r: RTL and testbench
============================

Name: fifo_1w1r

Overview:
- Synchronous show-ahead FIFO with a valid/ready handshake on both sides, built around the 1-write/1-read storage macro `mem_1w1r`.
- It owns all pointer, occupancy and flow-control logic and drives the macro's write and read ports.
- It absorbs the macro's one-cycle registered-address read latency so consumers see a stable, registered-valid output.
- Used as the buffering stage in front of the cache/pipeline consumers that need more depth than a skid buffer.

Parameters:
- ELEMENTS_W, 7, log2 of depth. DEPTH = 2**ELEMENTS_W; it must be at least 2.
- WIDTH, 32, data width in bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  synchronous clear of all entries.
- in_valid  in  1  producer has data.
- in_ready  out  1  FIFO can accept this cycle.
- in_data  in  WIDTH  write data.
- out_valid  out  1  out_data holds the head entry.
- out_ready  in  1  consumer takes the head this cycle.
- out_data  out  WIDTH  head entry. Driven directly from the macro readdata.
- count  out  ELEMENTS_W+1  total occupancy, 0..DEPTH.

Behaviour:
- Reset is synchronous and active-low. The one clock is clk.
- State: wptr and rptr, each ELEMENTS_W bits and wrapping modulo DEPTH; mem_count, ELEMENTS_W+1 bits; out_valid register.
- Reset values: wptr=0, rptr=0, mem_count=0, out_valid=0, count=0, in_ready=1. Memory contents are not reset.
- mem_count is the number of entries written but not yet loaded to the head.
- count = mem_count + out_valid. This is because the presented entry still occupies its storage slot.
- full = (count == DEPTH). in_ready = !full.
- in_ready is derived from registered state only. There is no combinational path from out_ready to in_ready.
- push = in_valid && in_ready. On push: the macro writes in_data at wptr, and wptr increments.
- load = (mem_count != 0) && (!out_valid || out_ready). On load: the macro is driven read=1 with readaddress=rptr, rptr increments, and out_valid goes to 1 next cycle.
- pop = out_valid && out_ready && !load. On pop: out_valid goes to 0.
- A simultaneous pop and load keeps out_valid=1 and presents the next entry from the next cycle.
- mem_count next = mem_count + push - load.
- Latency: an entry pushed at edge N into an empty FIFO gives out_valid=1 after edge N+1, i.e. 2 cycles.
- Throughput: 1 entry per cycle sustained in both directions.
- Head stability: while out_valid && !out_ready, out_data and out_valid are held.
  - The read address register is not updated.
  - The presented slot is never overwritten, because full accounting includes it.
- Full: with count==DEPTH and in_valid=1, nothing is written. A pop in that cycle makes in_ready=1 the next cycle.
- Empty: out_valid=0 and out_data is don't-care. out_ready is ignored.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no gap. Data order is preserved across the wrap.
- flush=1: next cycle wptr=rptr=0, mem_count=0, out_valid=0.
  - Flush has priority over push, load and pop in the same cycle.
  - The macro write is suppressed during flush.
- Reset mid-operation has the same effect as flush. It has priority over flush.
- Assertions: no push when full; no load when mem_count==0; count <= DEPTH.

Decomposition:
- Shared package: none required. DEPTH is a localparam.
- Sub-module: instantiate `mem_1w1r` for storage, passing ELEMENTS_W and WIDTH through. Its write and read ports connect to push/wptr/in_data and load/rptr.
- The control logic stays in one always block plus combinational next-state logic.

Test Plan:
- Reset, then push 0xA5 at cycle 0 with out_ready=1 → out_valid=1 with out_data=0xA5 after edge 1; count=1 then 0 after the pop.
- Push 0..DEPTH-1 (128 words) with out_ready=0 → in_ready=0 and count=128 after 128 pushes. A 129th push is dropped. Draining then returns 0..127 in order.
- Continuous push and pop every cycle for 1000 cycles with an incrementing pattern → no bubbles after the first 2 cycles, data in order across several pointer wraps, and count ≤ 2.
- Hold out_ready=0 with 3 entries present while pushing → out_data stays at the first entry every cycle until it is accepted.
- Random in_valid/out_ready at 50% each, checked against a scoreboard queue for 10k cycles → zero mismatches and count equal to the queue depth every cycle.
- Assert flush with 5 entries present while in_valid=1 → next cycle count=0 and out_valid=0, the concurrent push is discarded, and a subsequent push of 0x3C is the next value output.

Source files
------------

// File: rtl/fifo_1w1r_pkg.sv
// Shared defaults for the fifo_1w1r buffering stage and its storage macro.
package fifo_1w1r_pkg;

    localparam int unsigned DEF_ELEMENTS_W = 7;
    localparam int unsigned DEF_WIDTH      = 32;

endpackage

// File: rtl/fifo_1w1r_mem.sv
// 1-write/1-read storage macro: synchronous write, registered read address,
// readdata follows the registered address so it holds while read is low.
module mem_1w1r #(
    parameter int unsigned ELEMENTS_W = 7,
    parameter int unsigned WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  write,
    input  logic [ELEMENTS_W-1:0] writeaddress,
    input  logic [WIDTH-1:0]      writedata,
    input  logic                  read,
    input  logic [ELEMENTS_W-1:0] readaddress,
    output logic [WIDTH-1:0]      readdata
);

    localparam int unsigned DEPTH = 1 << ELEMENTS_W;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ELEMENTS_W-1:0] raddr_q;

    always_ff @(posedge clk) begin
        if (write) begin
            mem[writeaddress] <= writedata;
        end
        if (read) begin
            raddr_q <= readaddress;
        end
    end

    assign readdata = mem[raddr_q];

endmodule

// File: rtl/fifo_1w1r.sv
// Show-ahead valid/ready FIFO around mem_1w1r; the presented head keeps its
// storage slot until popped, so full accounting includes out_valid.
module fifo_1w1r
    import fifo_1w1r_pkg::*;
#(
    parameter int unsigned ELEMENTS_W = DEF_ELEMENTS_W,
    parameter int unsigned WIDTH      = DEF_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [ELEMENTS_W:0]   count
);

    localparam int unsigned           DEPTH     = 1 << ELEMENTS_W;
    localparam logic [ELEMENTS_W:0]   DEPTH_CNT = (ELEMENTS_W + 1)'(DEPTH);

    logic [ELEMENTS_W-1:0] wptr;
    logic [ELEMENTS_W-1:0] rptr;
    logic [ELEMENTS_W:0]   mem_count;
    logic [ELEMENTS_W:0]   mem_count_nxt;
    logic                  full;
    logic                  push;
    logic                  load;
    logic                  pop;
    logic                  mem_write;
    logic                  mem_read;

    always_comb begin
        count         = mem_count + {{ELEMENTS_W{1'b0}}, out_valid};
        full          = (count == DEPTH_CNT);
        in_ready      = !full;
        push          = in_valid && in_ready;
        load          = (mem_count != '0) && (!out_valid || out_ready);
        pop           = out_valid && out_ready && !load;
        // Flush and reset must not disturb storage or the read address.
        mem_write     = push && !flush && rst_n;
        mem_read      = load && !flush && rst_n;
        mem_count_nxt = mem_count + {{ELEMENTS_W{1'b0}}, push}
                                  - {{ELEMENTS_W{1'b0}}, load};
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wptr      <= '0;
            rptr      <= '0;
            mem_count <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (load) begin
                rptr <= rptr + 1'b1;
            end
            mem_count <= mem_count_nxt;
            if (load) begin
                out_valid <= 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
        end
    end

    mem_1w1r #(
        .ELEMENTS_W (ELEMENTS_W),
        .WIDTH      (WIDTH)
    ) u_mem (
        .clk          (clk),
        .write        (mem_write),
        .writeaddress (wptr),
        .writedata    (in_data),
        .read         (mem_read),
        .readaddress  (rptr),
        .readdata     (out_data)
    );

`ifndef SYNTHESIS
    assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
    assert property (@(posedge clk) disable iff (!rst_n) !(load && (mem_count == '0)));
    assert property (@(posedge clk) disable iff (!rst_n) count <= DEPTH_CNT);
`endif

endmodule

// File: tb/tb_fifo_1w1r.sv
// Scoreboard bench for fifo_1w1r: accepted inputs feed a reference queue,
// an output monitor pops and compares on every output handshake.
module tb_fifo_1w1r;

    localparam int unsigned EW    = 7;
    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 1 << EW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [EW:0]   count;

    int            checks = 0;
    int            failures = 0;
    logic [W-1:0]  exp_q[$];

    fifo_1w1r #(
        .ELEMENTS_W (EW),
        .WIDTH      (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Input side: occupancy check, then record what the next edge accepts.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("count_vs_model", 64'(count), 64'(exp_q.size()));
        end
        if (!rst_n || flush) begin
            exp_q.delete();
        end else if (in_valid && in_ready) begin
            exp_q.push_back(in_data);
        end
    end

    // Output side: compare the head on every handshake the next edge takes.
    always @(negedge clk) begin
        #1;
        if (rst_n && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("pop_from_empty_model", 64'(out_valid), 64'(0));
            end else begin
                chk("out_data_order", 64'(out_data), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4 * int'(DEPTH); i++) begin
            if (count == '0 && !out_valid) break;
            tick();
        end
        chk("drain_count", 64'(count), 64'(0));
        chk("drain_model_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_count", 64'(count), 64'(0));
        rst_n = 1'b1;

        // Single entry: latency and pop
        in_valid = 1'b1; in_data = 32'hA5; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_valid_after_push", 64'(out_valid), 64'(0));
        chk("lat_count_after_push", 64'(count), 64'(1));
        tick();
        chk("lat_valid_after_load", 64'(out_valid), 64'(1));
        chk("lat_data", 64'(out_data), 64'(32'hA5));
        chk("lat_count_presented", 64'(count), 64'(1));
        tick();
        chk("lat_valid_after_pop", 64'(out_valid), 64'(0));
        chk("lat_count_after_pop", 64'(count), 64'(0));

        // Fill to full, drop overflow push, drain in order
        out_ready = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            in_valid = 1'b1; in_data = W'(i);
            tick();
        end
        chk("full_in_ready", 64'(in_ready), 64'(0));
        chk("full_count", 64'(count), 64'(DEPTH));
        in_data = 32'hDEAD_BEEF;
        tick();
        chk("full_drop_count", 64'(count), 64'(DEPTH));
        chk("full_head", 64'(out_data), 64'(0));
        out_ready = 1'b1; in_valid = 1'b0;
        tick();
        chk("full_pop_in_ready", 64'(in_ready), 64'(1));
        drain();

        // Continuous streaming across several wraps
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            in_data = W'(c + 1000);
            tick();
            if (c >= 1) chk("stream_no_bubble", 64'(out_valid), 64'(1));
            chk("stream_count_le2", 64'(count <= 2), 64'(1));
        end
        drain();

        // Head held while consumer stalls
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = W'(32'h100 + i);
            tick();
            if (i >= 2) begin
                chk("hold_valid", 64'(out_valid), 64'(1));
                chk("hold_data", 64'(out_data), 64'(32'h100));
            end
        end
        drain();

        // Random traffic
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        drain();

        // Flush with concurrent push
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = W'(32'h200 + i);
            tick();
        end
        chk("preflush_count", 64'(count), 64'(5));
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h0BAD;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_count", 64'(count), 64'(0));
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        chk("flush_in_ready", 64'(in_ready), 64'(1));
        in_valid = 1'b1; in_data = 32'h3C; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("post_flush_valid", 64'(out_valid), 64'(1));
        chk("post_flush_data", 64'(out_data), 64'(32'h3C));
        drain();

        // Reset mid-operation clears like flush
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = W'(32'h300 + i);
            tick();
        end
        rst_n = 1'b0; in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_count", 64'(count), 64'(0));
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
